// File: rtl/pkt_adaptor_pkg.sv
// Shared definitions for the packet adaptor.
// Holds the request/response FSM state types, the default parameter
// values used by packet_adaptor and pkt_adaptor_ser, and a helper that
// sizes the shared beat counter.
package pkt_adaptor_pkg;

    localparam int PKT_S_DEF   = 32;
    localparam int KH_S_DEF    = 64;
    localparam int D_S_DEF     = 128;
    localparam int DT_S_DEF    = 3;
    localparam int TMO_CYC_DEF = 255;

    typedef enum logic [1:0] {
        REQ_HDR  = 2'd0,
        REQ_KEY  = 2'd1,
        REQ_WAIT = 2'd2
    } req_fsm_e;

    typedef enum logic [1:0] {
        RSP_IDLE = 2'd0,
        RSP_DATA = 2'd1,
        RSP_SEND = 2'd2
    } rsp_fsm_e;

    // One counter walks both the key beats and the response beats, so it is
    // sized for whichever phase is longer; a single-beat design still needs
    // a one-bit counter to stay legal.
    function automatic int cnt_width(input int key_beats, input int rsp_beats);
        int widest;
        widest = (key_beats > rsp_beats) ? key_beats : rsp_beats;
        return (widest > 1) ? $clog2(widest) : 1;
    endfunction

endpackage

// File: rtl/pkt_adaptor_ser.sv
// Response serialiser for packet_adaptor.
// Owns the response FSM (RSP_IDLE -> RSP_DATA -> RSP_SEND), the holding
// register for the private data word, the beat multiplexer, rsp_last and,
// when PKT_ADAPTOR_TIMEOUT_EN is defined, the response stall timeout.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           key-ready pulse from the request side
//   priv_data/valid private data word and its qualifier
//   rd_ready        downstream ready for response beats
//   beat_cnt        current response beat index (owned by the top)
//   data_out        response beat, 0 outside RSP_SEND
//   rsp_valid       high throughout RSP_SEND
//   rsp_last        high on the final response beat
//   rsp_abort       one-cycle pulse after a response timeout
//   beat_hs         a response beat transfers this cycle
//   rsp_end         response finishes this cycle (final beat or timeout)
//   state           response FSM state, for observation
module pkt_adaptor_ser
    import pkt_adaptor_pkg::*;
#(
    parameter int PKT_S   = PKT_S_DEF,
    parameter int D_S     = D_S_DEF,
    parameter int TMO_CYC = TMO_CYC_DEF,
    parameter int CW      = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [D_S-1:0]   priv_data,
    input  logic             priv_valid,
    input  logic             rd_ready,
    input  logic [CW-1:0]    beat_cnt,
    output logic [PKT_S-1:0] data_out,
    output logic             rsp_valid,
    output logic             rsp_last,
    output logic             rsp_abort,
    output logic             beat_hs,
    output logic             rsp_end,
    output rsp_fsm_e         state
);

    localparam int RSP_BEATS = D_S / PKT_S;

    if (TMO_CYC < 1) begin : g_tmo_check
        $error("pkt_adaptor_ser: TMO_CYC must be at least 1");
    end

    rsp_fsm_e         next_state;
    logic [D_S-1:0]   hold_reg;
    logic             stall_hit;

    assign rsp_valid = (state == RSP_SEND);
    assign beat_hs   = rsp_valid && rd_ready;
    assign rsp_last  = rsp_valid && (beat_cnt == CW'(RSP_BEATS - 1));
    assign rsp_end   = (beat_hs && rsp_last) || stall_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RSP_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            RSP_IDLE: if (start)      next_state = RSP_DATA;
            RSP_DATA: if (priv_valid) next_state = RSP_SEND;
            RSP_SEND: if (rsp_end)    next_state = RSP_IDLE;
            default:                  next_state = RSP_IDLE;
        endcase
    end

    // The secret word is sampled once; it stays put for the whole response
    // so every beat is stable while waiting on rd_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_reg <= '0;
        end else if (state == RSP_DATA && priv_valid) begin
            hold_reg <= priv_data;
        end
    end

    always_comb begin
        data_out = '0;
        if (state == RSP_SEND) begin
            data_out = hold_reg[int'(beat_cnt) * PKT_S +: PKT_S];
        end
    end

`ifdef PKT_ADAPTOR_TIMEOUT_EN
    localparam int SW = $clog2(TMO_CYC + 1);

    logic [SW-1:0] stall_cnt;
    logic          abort_q;

    // The counter reaches TMO_CYC on the edge where this fires, so the
    // abort pulse and the return to idle land together on that edge.
    assign stall_hit = rsp_valid && !beat_hs && (stall_cnt == SW'(TMO_CYC - 1));
    assign rsp_abort = abort_q;

    // Counter sits at zero outside RSP_SEND, which gives the clear on entry;
    // any transferred beat restarts the stall window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            abort_q   <= 1'b0;
        end else begin
            abort_q <= stall_hit;
            if (!rsp_valid || beat_hs || stall_hit) begin
                stall_cnt <= '0;
            end else begin
                stall_cnt <= stall_cnt + SW'(1);
            end
        end
    end
`else
    assign stall_hit = 1'b0;
    assign rsp_abort = 1'b0;
`endif

endmodule

// File: rtl/packet_adaptor.sv
// Packet adaptor top level.
// Assembles a request (one header beat carrying the request type, then
// KEY_BEATS key beats, most significant word first) into key_hash/req_type,
// pulses key_en, then hands off to pkt_adaptor_ser which serialises the
// private data word back out, least significant word first.
// Optional feature: define PKT_ADAPTOR_TIMEOUT_EN to enable the response
// stall timeout (rsp_abort); otherwise a stalled response waits forever.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   data_in, req_valid, req_ready request beat channel
//   data_out, rsp_valid, rd_ready, rsp_last  response beat channel
//   priv_data, priv_valid         private data word input
//   key_hash, req_type, key_en    assembled key, captured type, ready pulse
//   busy                          any FSM away from its idle state
//   rsp_abort                     one-cycle response timeout pulse
//   observe_port                  {req_fsm, rsp_fsm, beat_cnt[3:0]}
module packet_adaptor
    import pkt_adaptor_pkg::*;
#(
    parameter int PKT_S   = PKT_S_DEF,
    parameter int KH_S    = KH_S_DEF,
    parameter int D_S     = D_S_DEF,
    parameter int DT_S    = DT_S_DEF,
    parameter int TMO_CYC = TMO_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PKT_S-1:0] data_in,
    input  logic             req_valid,
    output logic             req_ready,
    output logic [PKT_S-1:0] data_out,
    output logic             rsp_valid,
    input  logic             rd_ready,
    output logic             rsp_last,
    input  logic [D_S-1:0]   priv_data,
    input  logic             priv_valid,
    output logic [KH_S-1:0]  key_hash,
    output logic [DT_S-1:0]  req_type,
    output logic             key_en,
    output logic             busy,
    output logic             rsp_abort,
    output logic [7:0]       observe_port
);

    localparam int KEY_BEATS = KH_S / PKT_S;
    localparam int RSP_BEATS = D_S / PKT_S;
    localparam int CW        = cnt_width(KEY_BEATS, RSP_BEATS);

    if ((KH_S % PKT_S) != 0 || (D_S % PKT_S) != 0 || DT_S > PKT_S) begin : g_param_check
        $error("packet_adaptor: KH_S and D_S must be multiples of PKT_S, DT_S <= PKT_S");
    end

    req_fsm_e      req_state;
    req_fsm_e      req_next;
    rsp_fsm_e      rsp_state;
    logic [CW-1:0] beat_cnt;
    logic          req_hs;
    logic          key_last;
    logic          beat_hs;
    logic          rsp_end;

    assign req_ready = (req_state == REQ_HDR) || (req_state == REQ_KEY);
    assign req_hs    = req_valid && req_ready;
    assign key_last  = (req_state == REQ_KEY) && (beat_cnt == CW'(KEY_BEATS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_state <= REQ_HDR;
        end else begin
            req_state <= req_next;
        end
    end

    // The request side parks in REQ_WAIT until the serialiser reports the
    // response finished, either by its last beat or by a timeout.
    always_comb begin
        req_next = req_state;
        case (req_state)
            REQ_HDR:  if (req_hs)             req_next = REQ_KEY;
            REQ_KEY:  if (req_hs && key_last) req_next = REQ_WAIT;
            REQ_WAIT: if (rsp_end)            req_next = REQ_HDR;
            default:                          req_next = REQ_HDR;
        endcase
    end

    // beat_cnt is shared: the key phase and the response phase never
    // overlap, and each phase leaves it at zero for the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt <= '0;
            key_hash <= '0;
            req_type <= '0;
            key_en   <= 1'b0;
        end else begin
            key_en <= req_hs && key_last;
            if (req_hs && req_state == REQ_HDR) begin
                req_type <= data_in[DT_S-1:0];
                beat_cnt <= '0;
            end else if (req_hs && req_state == REQ_KEY) begin
                key_hash <= (key_hash << PKT_S) | KH_S'(data_in);
                beat_cnt <= key_last ? '0 : beat_cnt + CW'(1);
            end else if (beat_hs) begin
                beat_cnt <= rsp_last ? '0 : beat_cnt + CW'(1);
            end else if (rsp_end) begin
                beat_cnt <= '0;
            end
        end
    end

    pkt_adaptor_ser #(
        .PKT_S   (PKT_S),
        .D_S     (D_S),
        .TMO_CYC (TMO_CYC),
        .CW      (CW)
    ) u_ser (
        .clk        (clk),
        .rst        (rst),
        .start      (key_en),
        .priv_data  (priv_data),
        .priv_valid (priv_valid),
        .rd_ready   (rd_ready),
        .beat_cnt   (beat_cnt),
        .data_out   (data_out),
        .rsp_valid  (rsp_valid),
        .rsp_last   (rsp_last),
        .rsp_abort  (rsp_abort),
        .beat_hs    (beat_hs),
        .rsp_end    (rsp_end),
        .state      (rsp_state)
    );

    assign busy         = (req_state != REQ_HDR) || (rsp_state != RSP_IDLE);
    assign observe_port = {req_state, rsp_state, 4'(beat_cnt)};

endmodule

// File: tb/tb_packet_adaptor.sv
// Self-checking bench for packet_adaptor with default widths and TMO_CYC=4.
// A cycle table covers the reference request/response, then randomised
// transactions are checked against a transaction-level model, followed by
// mid-response reset and response stall sequences.
module tb_packet_adaptor;

    localparam int PKT_S     = 32;
    localparam int KH_S      = 64;
    localparam int D_S       = 128;
    localparam int DT_S      = 3;
    localparam int TMO_CYC   = 4;
    localparam int RSP_BEATS = D_S / PKT_S;

    logic             clk = 1'b0;
    logic             rst;
    logic [PKT_S-1:0] data_in;
    logic             req_valid;
    logic             req_ready;
    logic [PKT_S-1:0] data_out;
    logic             rsp_valid;
    logic             rd_ready;
    logic             rsp_last;
    logic [D_S-1:0]   priv_data;
    logic             priv_valid;
    logic [KH_S-1:0]  key_hash;
    logic [DT_S-1:0]  req_type;
    logic             key_en;
    logic             busy;
    logic             rsp_abort;
    logic [7:0]       observe_port;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    packet_adaptor #(
        .PKT_S(PKT_S), .KH_S(KH_S), .D_S(D_S), .DT_S(DT_S), .TMO_CYC(TMO_CYC)
    ) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .req_valid(req_valid),
        .req_ready(req_ready), .data_out(data_out), .rsp_valid(rsp_valid),
        .rd_ready(rd_ready), .rsp_last(rsp_last), .priv_data(priv_data),
        .priv_valid(priv_valid), .key_hash(key_hash), .req_type(req_type),
        .key_en(key_en), .busy(busy), .rsp_abort(rsp_abort),
        .observe_port(observe_port)
    );

    typedef struct {
        logic        req_valid;
        logic [31:0] data_in;
        logic        priv_valid;
        logic        rd_ready;
        logic        exp_req_ready;
        logic        exp_key_en;
        logic        exp_rsp_valid;
        logic        exp_rsp_last;
        logic        exp_busy;
        logic [31:0] exp_data_out;
        logic [2:0]  exp_req_type;
        logic [63:0] exp_key_hash;
        logic [3:0]  exp_cnt;
    } vec_t;

    vec_t vecs[10];

    localparam logic [127:0] PRIV_REF = 128'h33333333_22222222_11111111_00000000;
    localparam logic [63:0]  KEY_REF  = 64'hDEADBEEF_01234567;

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic rv, input logic [31:0] din, input logic pv,
                                 input logic [127:0] pd, input logic rr);
        req_valid  = rv;
        data_in    = din;
        priv_valid = pv;
        priv_data  = pd;
        rd_ready   = rr;
    endtask

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_key_hash"}, key_hash, 0);
        checkOutput({tag, "_req_type"}, req_type, 0);
        checkOutput({tag, "_key_en"}, key_en, 0);
        checkOutput({tag, "_rsp_valid"}, rsp_valid, 0);
        checkOutput({tag, "_rsp_last"}, rsp_last, 0);
        checkOutput({tag, "_rsp_abort"}, rsp_abort, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_data_out"}, data_out, 0);
        checkOutput({tag, "_cnt"}, observe_port[3:0], 0);
    endtask

    // Transaction-level model: a request is header + key words (MS first),
    // the response must be the private word cut into PKT_S slices LS first.
    task automatic runTransaction(input logic [31:0] hdr, input logic [63:0] key,
                                  input logic [127:0] priv, input bit rnd, input int reset_after);
        logic [31:0] req_q[$];
        int          got = 0;
        int          key_seen = 0;
        int          budget = 0;
        int          low_run = 0;
        bit          key_due = 0;
        bit          stalled = 0;
        bit          do_reset = 0;
        logic [31:0] held = '0;
        logic        rv, pv, rr;
        logic [127:0] pd;
        req_q.push_back(hdr);
        req_q.push_back(key[63:32]);
        req_q.push_back(key[31:0]);
        while (got < RSP_BEATS) begin
            checkOutput("key_en", key_en, key_due);
            if (key_due) begin
                checkOutput("req_type", req_type, hdr[2:0]);
                checkOutput("key_hash", key_hash, key);
                key_seen++;
            end
            key_due = 0;
            checkOutput("req_ready", req_ready, req_q.size() > 0);
            if (stalled) begin
                checkOutput("hold_valid", rsp_valid, 1);
                checkOutput("hold_data", data_out, held);
            end
            if (rsp_valid) checkOutput("rsp_last", rsp_last, got == RSP_BEATS - 1);
            else           checkOutput("idle_data", data_out, 0);
            checkOutput("no_abort", rsp_abort, 0);

            rv = (req_q.size() > 0) ? (rnd ? 1'($urandom_range(0, 1)) : 1'b1)
                                    : (rnd ? 1'($urandom_range(0, 1)) : 1'b0);
            pv = rnd ? ($urandom_range(0, 2) == 0) : 1'b1;
            pd = pv ? priv : {$urandom, $urandom, $urandom, $urandom};
            rr = rnd ? (1'($urandom_range(0, 1)) || low_run >= 2) : 1'b1;
            low_run = rr ? 0 : low_run + 1;
            applyStimulus(rv, (req_q.size() > 0) ? req_q[0] : 32'hFFFF_FFFF, pv, pd, rr);

            if (rv && req_ready && req_q.size() > 0) begin
                void'(req_q.pop_front());
                if (req_q.size() == 0) key_due = 1;
            end
            if (rsp_valid && rr) begin
                checkOutput("beat_data", data_out, priv[got * 32 +: 32]);
                got++;
                stalled = 0;
                if (got == reset_after) do_reset = 1;
            end else begin
                stalled = rsp_valid;
                held    = data_out;
            end
            next_cycle();
            if (do_reset) begin
                rst = 1'b1;
                #1;
                checkResetState("mid_rst");
                applyStimulus(0, 0, 0, 0, 0);
                next_cycle();
                rst = 1'b0;
                checkOutput("rst_req_ready", req_ready, 1);
                return;
            end
            budget++;
            if (budget > 300) begin
                checks++;
                errors++;
                $display("[TB] FAIL txn_budget: got %0d beats expected %0d", got, RSP_BEATS);
                return;
            end
        end
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("key_en_count", key_seen, 1);
        checkOutput("end_req_ready", req_ready, 1);
        checkOutput("end_busy", busy, 0);
        checkOutput("end_rsp_valid", rsp_valid, 0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [127:0] p2;
        vecs[0] = '{1'b1, 32'h0000_0005, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 3'd0, 64'h0, 4'd0};
        vecs[1] = '{1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 3'd5, 64'h0, 4'd0};
        vecs[2] = '{1'b1, 32'h0123_4567, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 3'd5, 64'h0000_0000_DEAD_BEEF, 4'd1};
        vecs[3] = '{1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 3'd5, KEY_REF, 4'd0};
        vecs[4] = '{1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 3'd5, KEY_REF, 4'd0};
        vecs[5] = '{1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 3'd5, KEY_REF, 4'd0};
        vecs[6] = '{1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1111_1111, 3'd5, KEY_REF, 4'd1};
        vecs[7] = '{1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h2222_2222, 3'd5, KEY_REF, 4'd2};
        vecs[8] = '{1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h3333_3333, 3'd5, KEY_REF, 4'd3};
        vecs[9] = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 3'd5, KEY_REF, 4'd0};

        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0);
        #1;
        checkResetState("reset");
        next_cycle();
        next_cycle();
        rst = 1'b0;

        $display("[TB] directed reference transaction");
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("v%0d_req_ready", i), req_ready, vecs[i].exp_req_ready);
            checkOutput($sformatf("v%0d_key_en", i), key_en, vecs[i].exp_key_en);
            checkOutput($sformatf("v%0d_rsp_valid", i), rsp_valid, vecs[i].exp_rsp_valid);
            checkOutput($sformatf("v%0d_rsp_last", i), rsp_last, vecs[i].exp_rsp_last);
            checkOutput($sformatf("v%0d_busy", i), busy, vecs[i].exp_busy);
            checkOutput($sformatf("v%0d_data_out", i), data_out, vecs[i].exp_data_out);
            checkOutput($sformatf("v%0d_req_type", i), req_type, vecs[i].exp_req_type);
            checkOutput($sformatf("v%0d_key_hash", i), key_hash, vecs[i].exp_key_hash);
            checkOutput($sformatf("v%0d_cnt", i), observe_port[3:0], vecs[i].exp_cnt);
            applyStimulus(vecs[i].req_valid, vecs[i].data_in, vecs[i].priv_valid, PRIV_REF, vecs[i].rd_ready);
            next_cycle();
        end

        $display("[TB] randomised transactions");
        for (int t = 0; t < 12; t++) begin
            runTransaction($urandom, {$urandom, $urandom},
                           {$urandom, $urandom, $urandom, $urandom}, 1'b1, -1);
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) next_cycle();
        end

        $display("[TB] reset after second response beat");
        runTransaction(32'h6, 64'hCAFE_F00D_1234_5678, 128'h44444444_33333333_22222222_11111111, 1'b0, 2);
        runTransaction($urandom, {$urandom, $urandom},
                       {$urandom, $urandom, $urandom, $urandom}, 1'b1, -1);

        $display("[TB] response stall");
        p2 = 128'hD0D0D0D0_C0C0C0C0_B0B0B0B0_A0A0A0A0;
        applyStimulus(1, 32'h2, 0, 0, 0);
        next_cycle();
        applyStimulus(1, 32'h1111_2222, 0, 0, 0);
        next_cycle();
        applyStimulus(1, 32'h3333_4444, 0, 0, 0);
        next_cycle();
        applyStimulus(0, 0, 1, p2, 0);
        for (int i = 0; i < 10 && !rsp_valid; i++) next_cycle();
        checkOutput("stall_enter", rsp_valid, 1);
        applyStimulus(0, 0, 0, 0, 0);
`ifdef PKT_ADAPTOR_TIMEOUT_EN
        for (int k = 0; k < TMO_CYC; k++) begin
            checkOutput($sformatf("tmo_valid_%0d", k), rsp_valid, 1);
            checkOutput($sformatf("tmo_abort_%0d", k), rsp_abort, 0);
            checkOutput($sformatf("tmo_data_%0d", k), data_out, p2[31:0]);
            next_cycle();
        end
        checkOutput("tmo_abort_pulse", rsp_abort, 1);
        checkOutput("tmo_rsp_valid", rsp_valid, 0);
        checkOutput("tmo_req_ready", req_ready, 1);
        checkOutput("tmo_data_out", data_out, 0);
        next_cycle();
        checkOutput("tmo_abort_end", rsp_abort, 0);
        checkOutput("tmo_busy", busy, 0);
`else
        for (int k = 0; k < 20; k++) begin
            checkOutput($sformatf("hold_valid_%0d", k), rsp_valid, 1);
            checkOutput($sformatf("hold_abort_%0d", k), rsp_abort, 0);
            checkOutput($sformatf("hold_ready_%0d", k), req_ready, 0);
            checkOutput($sformatf("hold_data_%0d", k), data_out, p2[31:0]);
            next_cycle();
        end
        applyStimulus(0, 0, 0, 0, 1);
        for (int b = 0; b < RSP_BEATS; b++) begin
            checkOutput($sformatf("drain_data_%0d", b), data_out, p2[b * 32 +: 32]);
            checkOutput($sformatf("drain_last_%0d", b), rsp_last, b == RSP_BEATS - 1);
            next_cycle();
        end
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("drain_busy", busy, 0);
        checkOutput("drain_req_ready", req_ready, 1);
`endif
        runTransaction($urandom, {$urandom, $urandom},
                       {$urandom, $urandom, $urandom, $urandom}, 1'b1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/packet_adaptor.md
PACKET_ADAPTOR -- requirements
Module: packet_adaptor

Interface
REQ-001 Parameter PKT_S, default 32, meaning beat width in bits.
REQ-002 Parameter KH_S, default 64, meaning key-hash width; SHALL be an integer multiple of PKT_S, giving KEY_BEATS = KH_S/PKT_S.
REQ-003 Parameter D_S, default 128, meaning private-data width; SHALL be an integer multiple of PKT_S, giving RSP_BEATS = D_S/PKT_S.
REQ-004 Parameter DT_S, default 3, meaning request-type width; SHALL be <= PKT_S.
REQ-005 Parameter TMO_CYC, default 255, meaning response stall timeout in cycles; SHALL be >= 1.
REQ-006 Port clk, in, 1, meaning the single clock; all state is on its rising edge.
REQ-007 Port rst, in, 1, meaning reset, asynchronous and active-high.
REQ-008 Request ports: data_in (in, PKT_S, request beat); req_valid (in, 1); req_ready (out, 1).
REQ-009 Response ports: data_out (out, PKT_S, response beat); rsp_valid (out, 1); rd_ready (in, 1); rsp_last (out, 1, final beat).
REQ-010 Private-data ports: priv_data (in, D_S, secret word); priv_valid (in, 1, priv_data usable).
REQ-011 Key ports: key_hash (out, KH_S, assembled key); req_type (out, DT_S, captured type); key_en (out, 1, one-cycle key-ready pulse).
REQ-012 Status ports: busy (out, 1, any FSM not idle); rsp_abort (out, 1, one-cycle timeout pulse); observe_port (out, 8, {req_fsm[1:0], rsp_fsm[1:0], beat_cnt[3:0]}).

Function
REQ-013 A beat SHALL transfer only in a cycle where the valid and ready of its channel are both high.
REQ-014 The request FSM SHALL have states REQ_HDR, REQ_KEY, and REQ_WAIT; req_ready SHALL be high in REQ_HDR and REQ_KEY and low in REQ_WAIT.
REQ-015 The REQ_HDR beat SHALL load req_type from data_in[DT_S-1:0], clear beat_cnt, and move the FSM to REQ_KEY.
REQ-016 REQ_KEY SHALL take KEY_BEATS beats MS word first, each shifted into key_hash.
REQ-017 On the last key beat the request FSM SHALL move to REQ_WAIT, and key_en SHALL be high for exactly the next cycle.
REQ-018 The response FSM SHALL have states RSP_IDLE, RSP_DATA, and RSP_SEND; RSP_IDLE SHALL move to RSP_DATA in the same cycle key_en is high.
REQ-019 RSP_DATA SHALL wait indefinitely for priv_valid; on priv_valid it SHALL capture priv_data into a holding register and move to RSP_SEND.
REQ-020 In RSP_SEND, rsp_valid SHALL be high and data_out SHALL show holding word beat_cnt, LS word first.
REQ-021 rsp_last SHALL be high on beat RSP_BEATS-1.
REQ-022 The final beat's handshake SHALL return both FSMs to RSP_IDLE/REQ_HDR, raising req_ready in the next cycle.
REQ-023 While rsp_valid is high, data_out SHALL stay stable until the handshake.
REQ-024 Outside RSP_SEND, data_out SHALL be 0.
REQ-025 req_valid SHALL be ignored while req_ready is low; no beat is lost or buffered.
REQ-026 beat_cnt SHALL be sized $clog2(max(KEY_BEATS,RSP_BEATS)); observe_port SHALL zero-pad or truncate it to 4 bits.

Reset
REQ-027 rst high SHALL force, without waiting for a clock edge: REQ_HDR, RSP_IDLE, beat_cnt=0, key_hash=0, req_type=0, holding register=0, key_en=0, rsp_valid=0, rsp_last=0, rsp_abort=0, busy=0, data_out=0.
REQ-028 Reset mid-request or mid-response SHALL discard the partial transfer.
REQ-029 req_ready SHALL be high in the first cycle after rst falls.

Configuration
REQ-030 Macro PKT_ADAPTOR_TIMEOUT_EN SHALL control the response stall timeout.
REQ-031 With PKT_ADAPTOR_TIMEOUT_EN defined, a stall counter SHALL clear on entry to RSP_SEND and on every response handshake, and increment on every other RSP_SEND cycle.
REQ-032 With PKT_ADAPTOR_TIMEOUT_EN defined, when the stall counter reaches TMO_CYC the block SHALL pulse rsp_abort for one cycle, drop the response, and return to RSP_IDLE/REQ_HDR.
REQ-033 Without PKT_ADAPTOR_TIMEOUT_EN, the block SHALL have no stall counter, rsp_abort SHALL be tied to 0, and a stalled response SHALL wait indefinitely.

Structure
REQ-034 Shared package pkt_adaptor_pkg SHALL hold the req_fsm_e and rsp_fsm_e enums and the default parameter constants.
REQ-035 The response serialiser (holding register, beat mux, rsp_last, timeout) SHALL be the sub-module pkt_adaptor_ser; request assembly SHALL stay in the top module.

Verification
REQ-036 Bench SHALL cover: beats 0x5, 0xDEADBEEF, 0x01234567 with defaults -> req_type=3'd5, key_hash=0xDEADBEEF01234567, key_en high exactly one cycle.
REQ-037 Bench SHALL cover: priv_data=0x33333333_22222222_11111111_00000000, priv_valid high, rd_ready high -> data_out 0x00000000, 0x11111111, 0x22222222, 0x33333333 on consecutive cycles, rsp_last only on the fourth.
REQ-038 Bench SHALL cover: rd_ready toggled randomly during a response -> each beat held stable, no beat duplicated or skipped, req_ready low until the final handshake.
REQ-039 Bench SHALL cover: req_valid held high during REQ_WAIT with data 0xFFFFFFFF -> key_hash and req_type unchanged.
REQ-040 Bench SHALL cover: rst asserted after the second response beat -> all outputs 0 immediately, and a following complete request works normally.
REQ-041 Bench SHALL cover, with PKT_ADAPTOR_TIMEOUT_EN and TMO_CYC=4: rd_ready held low in RSP_SEND -> rsp_abort pulses after 4 stalled cycles, then req_ready=1; without the macro, rsp_valid held indefinitely.
